// File: rtl/weight_medium.sv
// weight_medium: moves one W_SIZE-bit weight word between a CPU-side port and a
// narrower BRAM, one BRAM_WIDTH beat per cycle, reassembling read beats after
// the BRAM read latency.
module weight_medium #(
    parameter int unsigned W_SIZE        = 1024,
    parameter int unsigned WEIGHT_LENGTH = 256,
    parameter int unsigned BRAM_WIDTH    = 64,
    parameter int unsigned BRAM_LATENCY  = 2,
    localparam int unsigned BEATS        = W_SIZE / BRAM_WIDTH,
    localparam int unsigned A_SIZE       = $clog2(WEIGHT_LENGTH),
    localparam int unsigned B_SIZE       = $clog2(BEATS)
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [A_SIZE-1:0]          weight_pointer_in,
    input  logic [W_SIZE-1:0]          write_data_in,
    output logic [W_SIZE-1:0]          read_data_out,
    input  logic                       read_enable_in,
    input  logic                       write_enable_in,
    output logic                       finished_out,
    output logic                       busy_out,
    output logic [A_SIZE+B_SIZE-1:0]   bram_addr_out,
    output logic [BRAM_WIDTH-1:0]      bram_din_out,
    input  logic [BRAM_WIDTH-1:0]      bram_dout_in,
    output logic                       bram_en_out,
    output logic                       bram_we_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                    r_state;
    logic [A_SIZE-1:0]         r_ptr;
    logic [B_SIZE-1:0]         r_beat;
    logic [W_SIZE-1:0]         r_wdata;
    logic [W_SIZE-1:0]         r_asm;
    logic [W_SIZE-1:0]         r_read_data;
    logic                      r_finished;
    logic                      r_busy;
    logic                      r_en;
    logic                      r_we;
    logic [A_SIZE+B_SIZE-1:0]  r_addr;
    logic [BRAM_WIDTH-1:0]     r_din;
    logic [BRAM_LATENCY-1:0]   r_vld_pipe;
    logic [B_SIZE-1:0]         r_idx_pipe [BRAM_LATENCY];

    logic                      w_rd_issue;
    logic                      w_last_beat;
    logic [B_SIZE-1:0]         w_beat_nxt;
    logic [BRAM_WIDTH-1:0]     w_wr_beat;
    logic                      w_cap_vld;
    logic [B_SIZE-1:0]         w_cap_idx;
    logic                      w_cap_last;
    logic [W_SIZE-1:0]         w_asm_next;

    assign w_rd_issue  = r_en & ~r_we;
    assign w_last_beat = (r_beat == B_SIZE'(BEATS - 1));
    assign w_beat_nxt  = r_beat + B_SIZE'(1);
    assign w_wr_beat   = r_wdata[int'(w_beat_nxt) * BRAM_WIDTH +: BRAM_WIDTH];
    assign w_cap_vld   = r_vld_pipe[BRAM_LATENCY-1];
    assign w_cap_idx   = r_idx_pipe[BRAM_LATENCY-1];
    assign w_cap_last  = w_cap_vld && (w_cap_idx == B_SIZE'(BEATS - 1));

    assign read_data_out = r_read_data;
    assign finished_out  = r_finished;
    assign busy_out      = r_busy;
    assign bram_addr_out = r_addr;
    assign bram_din_out  = r_din;
    assign bram_en_out   = r_en;
    assign bram_we_out   = r_we;

    // Assembly word with the beat arriving this cycle merged in.
    always_comb begin
        w_asm_next = r_asm;
        w_asm_next[int'(w_cap_idx) * BRAM_WIDTH +: BRAM_WIDTH] = bram_dout_in;
    end

    // Read capture pipeline: tracks which beat's data arrives BRAM_LATENCY cycles after its address.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_vld_pipe <= '0;
            for (int i = 0; i < int'(BRAM_LATENCY); i++) begin
                r_idx_pipe[i] <= '0;
            end
            r_asm <= '0;
        end else begin
            r_vld_pipe[0] <= w_rd_issue;
            r_idx_pipe[0] <= r_beat;
            for (int i = 1; i < int'(BRAM_LATENCY); i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_idx_pipe[i] <= r_idx_pipe[i-1];
            end
            if (w_cap_vld) begin
                r_asm <= w_asm_next;
            end
        end
    end

    // Transfer FSM with registered BRAM and CPU-side outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_beat      <= '0;
            r_wdata     <= '0;
            r_read_data <= '0;
            r_finished  <= 1'b0;
            r_busy      <= 1'b0;
            r_en        <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_din       <= '0;
        end else begin
            r_finished <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_en   <= 1'b0;
                    r_we   <= 1'b0;
                    r_busy <= 1'b0;
                    if (write_enable_in) begin
                        // Write has priority; a simultaneous read is dropped.
                        r_state <= S_WRITE;
                        r_ptr   <= weight_pointer_in;
                        r_wdata <= write_data_in;
                        r_beat  <= '0;
                        r_en    <= 1'b1;
                        r_we    <= 1'b1;
                        r_addr  <= {weight_pointer_in, B_SIZE'(0)};
                        r_din   <= write_data_in[BRAM_WIDTH-1:0];
                        r_busy  <= 1'b1;
                    end else if (read_enable_in) begin
                        r_state <= S_READ;
                        r_ptr   <= weight_pointer_in;
                        r_beat  <= '0;
                        r_en    <= 1'b1;
                        r_we    <= 1'b0;
                        r_addr  <= {weight_pointer_in, B_SIZE'(0)};
                        r_busy  <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (w_last_beat) begin
                        r_en       <= 1'b0;
                        r_we       <= 1'b0;
                        r_state    <= S_DONE;
                        r_finished <= 1'b1;
                    end else begin
                        r_beat <= w_beat_nxt;
                        r_addr <= {r_ptr, w_beat_nxt};
                        r_din  <= w_wr_beat;
                    end
                end
                S_READ: begin
                    if (r_en) begin
                        if (w_last_beat) begin
                            r_en <= 1'b0;
                        end else begin
                            r_beat <= w_beat_nxt;
                            r_addr <= {r_ptr, w_beat_nxt};
                        end
                    end
                    // Publish only the complete word, in the same edge as the last beat lands.
                    if (w_cap_last) begin
                        r_read_data <= w_asm_next;
                        r_state     <= S_DONE;
                        r_finished  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_medium.sv
// tb_weight_medium: randomized + directed stimulus with a transaction-level
// reference model feeding scoreboard queues, and a per-cycle monitor.
module tb_weight_medium;

    localparam int unsigned W_SIZE = 1024;
    localparam int unsigned BW     = 64;
    localparam int unsigned LAT    = 2;
    localparam int unsigned BEATS  = W_SIZE / BW;
    localparam int unsigned NWORDS = 256;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic [7:0]        weight_pointer_in;
    logic [W_SIZE-1:0] write_data_in;
    logic [W_SIZE-1:0] read_data_out;
    logic              read_enable_in;
    logic              write_enable_in;
    logic              finished_out;
    logic              busy_out;
    logic [11:0]       bram_addr_out;
    logic [BW-1:0]     bram_din_out;
    logic [BW-1:0]     bram_dout_in;
    logic              bram_en_out;
    logic              bram_we_out;

    weight_medium dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .weight_pointer_in (weight_pointer_in),
        .write_data_in     (write_data_in),
        .read_data_out     (read_data_out),
        .read_enable_in    (read_enable_in),
        .write_enable_in   (write_enable_in),
        .finished_out      (finished_out),
        .busy_out          (busy_out),
        .bram_addr_out     (bram_addr_out),
        .bram_din_out      (bram_din_out),
        .bram_dout_in      (bram_dout_in),
        .bram_en_out       (bram_en_out),
        .bram_we_out       (bram_we_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Deterministic power-up contents of every BRAM address.
    function automatic logic [63:0] init_val(input int a);
        logic [31:0] ua;
        ua = 32'(a);
        return {(ua * 32'h9E3779B9) ^ 32'h5A5A0000, ~(ua * 32'h85EBCA6B)};
    endfunction

    // BRAM model with LAT-cycle read latency; unread cycles return noise.
    logic [63:0] mem     [4096];
    bit          written [4096];
    logic [63:0] rd_pipe [LAT];
    always @(posedge clk_in) begin
        if (bram_en_out && bram_we_out) begin
            mem[bram_addr_out]     <= bram_din_out;
            written[bram_addr_out] <= 1'b1;
        end
        if (bram_en_out && !bram_we_out)
            rd_pipe[0] <= written[bram_addr_out] ? mem[bram_addr_out] : init_val(int'(bram_addr_out));
        else
            rd_pipe[0] <= {$urandom, $urandom};
        for (int i = 1; i < int'(LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bram_dout_in = rd_pipe[LAT-1];

    typedef struct {
        int          cyc;
        logic [11:0] addr;
        bit          we;
        logic [63:0] din;
    } acc_t;

    typedef struct {
        int                cyc;
        bit                is_read;
        logic [W_SIZE-1:0] data;
    } fin_t;

    acc_t acc_q[$];
    fin_t fin_q[$];

    int errors = 0;
    int checks = 0;

    // Reference model state (word-level view of storage and transaction timing).
    logic [W_SIZE-1:0] ref_word [NWORDS];
    int                free_cyc  = 0;
    int                busy_from = -1;
    int                busy_to   = -1;
    int                pw_start  = -1;
    int                pw_ptr    = 0;
    logic [W_SIZE-1:0] pw_old;

    function automatic logic [W_SIZE-1:0] rand_word();
        logic [W_SIZE-1:0] w;
        for (int i = 0; i < int'(W_SIZE / 32); i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Predict every BRAM access and completion caused by the inputs of cycle n.
    task automatic model_step(input int n);
        int p;
        acc_t a;
        fin_t f;
        p = int'(weight_pointer_in);
        if (rst_in) begin
            while (acc_q.size() > 0 && acc_q[$].cyc > n) void'(acc_q.pop_back());
            while (fin_q.size() > 0 && fin_q[$].cyc > n) void'(fin_q.pop_back());
            if (busy_to > n) busy_to = n;
            if (pw_start >= 0) begin
                for (int k = 0; k < int'(BEATS); k++)
                    if (pw_start + 1 + k > n) ref_word[pw_ptr][k*64 +: 64] = pw_old[k*64 +: 64];
            end
            pw_start = -1;
            free_cyc = n + 1;
        end else if (n >= free_cyc && (write_enable_in || read_enable_in)) begin
            busy_from = n + 1;
            if (write_enable_in) begin
                pw_old      = ref_word[p];
                ref_word[p] = write_data_in;
                pw_start    = n;
                pw_ptr      = p;
                for (int k = 0; k < int'(BEATS); k++) begin
                    a.cyc = n + 1 + k; a.addr = 12'(p * int'(BEATS) + k); a.we = 1'b1;
                    a.din = write_data_in[k*64 +: 64];
                    acc_q.push_back(a);
                end
                f.cyc = n + int'(BEATS) + 1; f.is_read = 1'b0; f.data = '0;
                fin_q.push_back(f);
                busy_to  = n + int'(BEATS) + 1;
                free_cyc = n + int'(BEATS) + 2;
            end else begin
                pw_start = -1;
                for (int k = 0; k < int'(BEATS); k++) begin
                    a.cyc = n + 1 + k; a.addr = 12'(p * int'(BEATS) + k); a.we = 1'b0; a.din = '0;
                    acc_q.push_back(a);
                end
                f.cyc = n + int'(BEATS) + int'(LAT) + 1; f.is_read = 1'b1; f.data = ref_word[p];
                fin_q.push_back(f);
                busy_to  = n + int'(BEATS) + int'(LAT) + 1;
                free_cyc = n + int'(BEATS) + int'(LAT) + 2;
            end
        end
    endtask

    task automatic drive(input bit rst, input bit we, input bit re, input logic [7:0] ptr,
                         input logic [W_SIZE-1:0] d);
        @(posedge clk_in);
        #1;
        rst_in            = rst;
        write_enable_in   = we;
        read_enable_in    = re;
        weight_pointer_in = ptr;
        write_data_in     = d;
        model_step(cyc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'($urandom), rand_word());
    endtask

    function automatic int first_diff(input logic [W_SIZE-1:0] a, input logic [W_SIZE-1:0] b);
        for (int k = 0; k < int'(BEATS); k++) if (a[k*64 +: 64] !== b[k*64 +: 64]) return k;
        return 0;
    endfunction

    // Monitor: compares DUT outputs every cycle against the scoreboard queues.
    bit                prev_rst  = 1'b1;
    logic [W_SIZE-1:0] exp_rdata = '0;
    initial begin
        int c;
        int k;
        bit exp_busy;
        forever begin
            @(negedge clk_in);
            c = cyc;
            if (prev_rst) begin
                exp_rdata = '0;
                checks++;
                if (busy_out !== 1'b0 || finished_out !== 1'b0 || bram_en_out !== 1'b0 ||
                    bram_we_out !== 1'b0 || bram_addr_out !== 12'd0 || bram_din_out !== 64'd0) begin
                    errors++;
                    $display("FAIL reset_state cyc=%0d got busy=%b fin=%b en=%b we=%b addr=%0d din=%h, expected all zero",
                             c, busy_out, finished_out, bram_en_out, bram_we_out, bram_addr_out, bram_din_out);
                end
            end
            exp_busy = (c >= busy_from) && (c <= busy_to);
            checks++;
            if (busy_out !== exp_busy) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b expected=%b", c, busy_out, exp_busy);
            end
            while (acc_q.size() > 0 && acc_q[0].cyc < c) begin
                checks++; errors++;
                $display("FAIL access_missed cyc=%0d got=none expected addr=%0d at cyc %0d", c, acc_q[0].addr, acc_q[0].cyc);
                void'(acc_q.pop_front());
            end
            if (bram_en_out === 1'b1) begin
                checks++;
                if (acc_q.size() == 0 || acc_q[0].cyc != c) begin
                    errors++;
                    $display("FAIL access_unexpected cyc=%0d got en=1 we=%b addr=%0d expected en=0", c, bram_we_out, bram_addr_out);
                end else begin
                    if (bram_addr_out !== acc_q[0].addr || bram_we_out !== acc_q[0].we ||
                        (acc_q[0].we && bram_din_out !== acc_q[0].din)) begin
                        errors++;
                        $display("FAIL access cyc=%0d got addr=%0d we=%b din=%h expected addr=%0d we=%b din=%h",
                                 c, bram_addr_out, bram_we_out, bram_din_out, acc_q[0].addr, acc_q[0].we, acc_q[0].din);
                    end
                    void'(acc_q.pop_front());
                end
            end else begin
                checks++;
                if (bram_we_out !== 1'b0) begin
                    errors++;
                    $display("FAIL we_without_en cyc=%0d got we=%b expected 0", c, bram_we_out);
                end
                if (acc_q.size() > 0 && acc_q[0].cyc == c) begin
                    checks++; errors++;
                    $display("FAIL access_missing cyc=%0d got en=%b expected addr=%0d", c, bram_en_out, acc_q[0].addr);
                    void'(acc_q.pop_front());
                end
            end
            while (fin_q.size() > 0 && fin_q[0].cyc < c) begin
                checks++; errors++;
                $display("FAIL finished_missed cyc=%0d got=none expected at cyc %0d", c, fin_q[0].cyc);
                void'(fin_q.pop_front());
            end
            checks++;
            if (finished_out === 1'b1) begin
                if (fin_q.size() == 0 || fin_q[0].cyc != c) begin
                    errors++;
                    $display("FAIL finished_unexpected cyc=%0d got=1 expected=0", c);
                end else begin
                    if (fin_q[0].is_read) exp_rdata = fin_q[0].data;
                    void'(fin_q.pop_front());
                end
            end else if (fin_q.size() > 0 && fin_q[0].cyc == c) begin
                errors++;
                $display("FAIL finished_missing cyc=%0d got=%b expected=1", c, finished_out);
                void'(fin_q.pop_front());
            end
            checks++;
            if (read_data_out !== exp_rdata) begin
                errors++;
                k = first_diff(read_data_out, exp_rdata);
                $display("FAIL read_data cyc=%0d beat %0d got=%h expected=%h",
                         c, k, read_data_out[k*64 +: 64], exp_rdata[k*64 +: 64]);
            end
            prev_rst = rst_in;
        end
    end

    // Directed scenarios followed by a randomized phase.
    initial begin
        logic [W_SIZE-1:0] d;
        rst_in            = 1'b1;
        write_enable_in   = 1'b0;
        read_enable_in    = 1'b0;
        weight_pointer_in = '0;
        write_data_in     = '0;
        for (int p = 0; p < int'(NWORDS); p++)
            for (int k = 0; k < int'(BEATS); k++)
                ref_word[p][k*64 +: 64] = init_val(p * int'(BEATS) + k);

        repeat (3) drive(1'b1, 1'b0, 1'b0, 8'd0, '0);
        idle(3);

        // Write pointer 5 with beat k = 0x1111...*k, then read it back.
        for (int k = 0; k < int'(BEATS); k++) d[k*64 +: 64] = 64'h1111111111111111 * 64'(k);
        drive(1'b0, 1'b1, 1'b0, 8'd5, d);
        idle(20);
        drive(1'b0, 1'b0, 1'b1, 8'd5, rand_word());
        idle(22);

        // Both enables: write wins, read dropped.
        drive(1'b0, 1'b1, 1'b1, 8'd3, rand_word());
        idle(20);

        // Read held for 30 cycles: two back-to-back reads.
        for (int i = 0; i < 30; i++) drive(1'b0, 1'b0, 1'b1, 8'd5, rand_word());
        idle(25);

        // Reset in cycle E+8 of a write, then read an untouched pointer and the torn one.
        drive(1'b0, 1'b1, 1'b0, 8'd7, rand_word());
        idle(7);
        drive(1'b1, 1'b1, 1'b1, 8'd9, rand_word());
        idle(3);
        drive(1'b0, 1'b0, 1'b1, 8'd9, rand_word());
        idle(22);
        drive(1'b0, 1'b0, 1'b1, 8'd7, rand_word());
        idle(22);

        // Maximum pointer.
        drive(1'b0, 1'b0, 1'b1, 8'd255, rand_word());
        idle(22);

        // Random traffic, including enables while busy and occasional resets.
        for (int i = 0; i < 1500; i++)
            drive($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0,
                  8'($urandom), rand_word());
        idle(40);

        @(negedge clk_in);
        #1;
        checks++;
        if (acc_q.size() != 0 || fin_q.size() != 0) begin
            errors++;
            $display("FAIL drain got acc=%0d fin=%0d pending expected 0", acc_q.size(), fin_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
